dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory (`dmem`) between the core load/store unit (port 0) and a debug/loader port (port 1). It accepts requests over a valid/ready handshake, drives the `dmem` control, address and data pins for the granted port, and returns registered read data or a write acknowledge one cycle later. Misaligned accesses are rejected before they reach memory. It sits between the pipeline MEM stage, the debug port and `dmem`.

## Interface
- `PRIO_MODE`, default 0: 0 = round-robin, 1 = fixed priority (port 0 always wins).
- `ADDR_W`, default 32: address width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `p0_valid`, `p1_valid` in 1: request valid.
- `p0_ready`, `p1_ready` out 1: request accepted this cycle (combinational grant).
- `p0_we`, `p1_we` in 1: 1 = store, 0 = load.
- `p0_lock`, `p1_lock` in 1: hold the grant on the next cycle, for read-modify-write sequences.
- `p0_addr`, `p1_addr` in `ADDR_W`: byte address.
- `p0_rwtype`, `p1_rwtype` in 3: RW_type field. [1:0]: 00 byte, 01 half, 10 word. [2]: unsigned load.
- `p0_wdata`, `p1_wdata` in 32: store data, right-aligned.
- `p0_rsp_valid`, `p1_rsp_valid` out 1: one-cycle response pulse.
- `p0_rsp_err`, `p1_rsp_err` out 1: misaligned access; valid while `rsp_valid` is high.
- `p0_rdata`, `p1_rdata` out 32: load result, extended by `dmem`.
- `m_W_en`, `m_R_en` out 1: to `dmem`.
- `m_addr` out 32: to `dmem`.
- `m_RW_type` out 3: to `dmem`.
- `m_din` out 32: to `dmem`.
- `m_dout` in 32: from `dmem` (combinational read).

## Operation
- **Grant selection, each cycle:**
  - If `lock_q` is set and the locked port is valid, that port wins.
  - Otherwise, if only one port is valid, it wins.
  - If both are valid:
    - `PRIO_MODE`=1: port 0 wins.
    - `PRIO_MODE`=0: the port other than `last_q` wins.
- **Grant register updates:**
  - `last_q` updates to the winner on every accepted request.
  - `lock_q` is set to `winner_lock` on accept. It clears when no request is accepted.
- **Accept:** `pX_ready` = grant. A request is accepted when valid and ready are both high. Exactly one port is accepted per cycle, at most.
- **Alignment check:**
  - Half access with `addr[0]`=1 is misaligned.
  - Word access with `addr[1:0]`≠00 is misaligned.
  - RW_type[1:0]=11 is an error.
  - An erroring request is still accepted (ready high) but does not touch memory: `m_W_en`=`m_R_en`=0.
- **Memory drive:** for an aligned accepted request:
  - `m_W_en` = we.
  - `m_R_en` = !we.
  - addr, RW_type and din pass through from the winner.
  - With no accept, all `m_*` enables are 0 and the data/addr outputs are don't-care. Drive them to 0.
- **Response capture:** on the accept edge, capture:
  - `rsp_port_q` = winner.
  - `rsp_err_q`.
  - `rdata_q` = `m_dout` for aligned loads only.
- **Response output:**
  - Next cycle, `pX_rsp_valid` pulses high for exactly the winner.
  - `pX_rdata` = `rdata_q` on both ports. The consumer qualifies it with its own `rsp_valid`.
  - `rdata_q` holds until the next aligned load.
- **Simultaneous events:** a new request may be accepted in the same cycle a response is presented. Full throughput is one access per cycle.
- **Reset:** asynchronous, clears all state:
  - `rsp_valid`=0, `rsp_err`=0, `rdata_q`=0, `lock_q`=0.
  - `last_q`=1, so port 0 wins the first tie.
  - While `rst_n`=0, `pX_ready`, `m_W_en` and `m_R_en` are forced to 0, so no store commits during reset.
  - A response pending at reset assertion is dropped.

## Timing
- **Latency:** request accept at cycle N. Store commits to `dmem` at the N edge. Response (ack/data/err) is visible in cycle N+1.
- **Combinational paths:** `pX_ready` depends combinationally on both `valid`s, `lock_q` and `last_q`. There is no path from `m_dout` to any output.
- **Lock:** the locked port is granted in cycle N+1 even if the other port is valid, provided the locked port is valid. If the locked port is not valid, the lock drops and the other port may win.
- **Starvation bound:** in `PRIO_MODE`=0 without lock, a valid port waits at most 1 cycle.

## Structure
- **Shared defines (`xgriscv_defines.v`):** RW_type encodings `RW_B`=00, `RW_H`=01, `RW_W`=10, and `RW_U` bit index 2.
- **Sub-module `arb_rr2`:** two-requester pick logic. Inputs: valids, `last_q`, `lock_q`/lock port, mode. Outputs: one-hot grant and winner index.
- **Arbiter body:** alignment check, muxing and response registers stay in `dmem_arbiter`.

## Test plan
- Reset, then p0 stores word 0x12345678 to 0x10, then loads 0x10 → p0_rsp_valid at N+1 both times, `p0_rdata`=0x12345678, err=0.
- p0 and p1 both hold valid loads for 4 cycles, `PRIO_MODE`=0 → grants 0,1,0,1. With `PRIO_MODE`=1 → 0,0,0,0.
- p1 lock=1, reads 0x20 then writes byte 0xAA to 0x21, while p0 is valid throughout → p1 granted both cycles, p0 granted on the 3rd cycle. Word at 0x20 shows byte1=0xAA.
- p0 loads half at 0x13 → accepted, `m_R_en`=0, p0_rsp_err=1 at N+1, `rdata` unchanged. A word load at 0x22 also errors.
- Signed byte load of 0x80 at 0x30 → 0xFFFFFF80. Unsigned (RW_type=100) → 0x00000080.
- Assert `rst_n` low during an accepted store cycle → no memory change. After release, `rsp_valid`=0 and p0 wins the first tie.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

  // RW_type size field encodings; bit RW_U selects an unsigned load.
  localparam logic [1:0] RW_B = 2'b00;
  localparam logic [1:0] RW_H = 2'b01;
  localparam logic [1:0] RW_W = 2'b10;
  localparam int         RW_U = 2;

  // Arbitration policy selector values for PRIO_MODE.
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // A request is rejected when its size does not fit its byte offset,
  // or when the size field holds the reserved encoding.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      RW_B:    bad = 1'b0;
      RW_H:    bad = addr_lo[0];
      RW_W:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_arb.sv
// Two-requester pick logic: lock hold, then single requester, then tie-break.
module arb_rr2
  import dmem_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic [1:0] valid,
  input  logic       last_q,
  input  logic       lock_q,
  input  logic       lock_port,
  output logic [1:0] grant,
  output logic       winner
);

  logic any;

  // Choose the winner; grant is one-hot and empty when nobody requests.
  always_comb begin
    winner = 1'b0;
    any    = 1'b0;
    if (lock_q && valid[lock_port]) begin
      winner = lock_port;
      any    = 1'b1;
    end else if (valid == 2'b11) begin
      winner = (PRIO_MODE == PRIO_FIXED) ? 1'b0 : ~last_q;
      any    = 1'b1;
    end else if (valid[0]) begin
      winner = 1'b0;
      any    = 1'b1;
    end else if (valid[1]) begin
      winner = 1'b1;
      any    = 1'b1;
    end
    grant = any ? (winner ? 2'b10 : 2'b01) : 2'b00;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dmem between the load/store unit (port 0) and the debug/loader
// port (port 1); one access per cycle, response registered one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  input  logic              p1_valid,
  output logic              p0_ready,
  output logic              p1_ready,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic              p0_lock,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [2:0]        p0_rwtype,
  input  logic [2:0]        p1_rwtype,
  input  logic [31:0]       p0_wdata,
  input  logic [31:0]       p1_wdata,
  output logic              p0_rsp_valid,
  output logic              p1_rsp_valid,
  output logic              p0_rsp_err,
  output logic              p1_rsp_err,
  output logic [31:0]       p0_rdata,
  output logic [31:0]       p1_rdata,
  output logic              m_W_en,
  output logic              m_R_en,
  output logic [31:0]       m_addr,
  output logic [2:0]        m_RW_type,
  output logic [31:0]       m_din,
  input  logic [31:0]       m_dout
);

  logic [1:0]        req_vld;
  logic [1:0]        grant;
  logic              winner;
  logic              accept;
  logic              last_q;
  logic              lock_q;
  logic              w_we;
  logic              w_lock;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_rwtype;
  logic [31:0]       w_wdata;
  logic [31:0]       addr_ext;
  logic              req_err;
  logic              mem_ok;
  logic              rsp_valid_q;
  logic              rsp_port_q;
  logic              rsp_err_q;
  logic [31:0]       rdata_q;

  // Requests are masked while reset is held so nothing is granted or stored.
  assign req_vld = {p1_valid, p0_valid} & {2{rst_n}};

  arb_rr2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .valid     (req_vld),
    .last_q    (last_q),
    .lock_q    (lock_q),
    .lock_port (last_q),
    .grant     (grant),
    .winner    (winner)
  );

  // The lock always belongs to the last winner, so last_q doubles as lock port.
  assign p0_ready = grant[0];
  assign p1_ready = grant[1];
  assign accept   = |grant;

  assign w_we     = winner ? p1_we     : p0_we;
  assign w_lock   = winner ? p1_lock   : p0_lock;
  assign w_addr   = winner ? p1_addr   : p0_addr;
  assign w_rwtype = winner ? p1_rwtype : p0_rwtype;
  assign w_wdata  = winner ? p1_wdata  : p0_wdata;

  generate
    if (ADDR_W >= 32) begin : g_addr_trunc
      assign addr_ext = w_addr[31:0];
    end else begin : g_addr_zext
      assign addr_ext = {{(32 - ADDR_W){1'b0}}, w_addr};
    end
  endgenerate

  assign req_err = is_misaligned(w_rwtype[1:0], w_addr[1:0]);
  assign mem_ok  = accept & ~req_err;

  // Drive dmem only for an accepted, aligned request; park everything at 0 otherwise.
  always_comb begin
    m_W_en    = 1'b0;
    m_R_en    = 1'b0;
    m_addr    = '0;
    m_RW_type = '0;
    m_din     = '0;
    if (mem_ok) begin
      m_W_en    = w_we;
      m_R_en    = ~w_we;
      m_addr    = addr_ext;
      m_RW_type = w_rwtype;
      m_din     = w_wdata;
    end
  end

  // Arbitration history and response handshake state, updated on each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      last_q      <= winner;
      lock_q      <= w_lock;
      rsp_valid_q <= 1'b1;
      rsp_port_q  <= winner;
      rsp_err_q   <= req_err;
    end else begin
      lock_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end
  end

  // Load data register; only aligned loads overwrite it, so it holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (mem_ok && !w_we) begin
      rdata_q <= m_dout;
    end
  end

  // ---- response stage: one-cycle pulse routed to the port that won ----
  assign p0_rsp_valid = rsp_valid_q & ~rsp_port_q;
  assign p1_rsp_valid = rsp_valid_q &  rsp_port_q;
  assign p0_rsp_err   = rsp_err_q & p0_rsp_valid;
  assign p1_rsp_err   = rsp_err_q & p1_rsp_valid;
  assign p0_rdata     = rdata_q;
  assign p1_rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed dmem model and a
// response scoreboard; a second instance runs fixed-priority arbitration.
module tb_dmem_arbiter;

  typedef struct {
    logic [1:0]  vld;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        p0_valid, p1_valid, p0_we, p1_we, p0_lock, p1_lock;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [2:0]  p0_rwtype, p1_rwtype;
  logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        m_W_en, m_R_en;
  logic [31:0] m_addr, m_din, m_dout;
  logic [2:0]  m_RW_type;

  logic        fp_p0_ready, fp_p1_ready, fp_p0_rsp_valid, fp_p1_rsp_valid;
  logic        fp_p0_rsp_err, fp_p1_rsp_err, fp_m_W_en, fp_m_R_en;
  logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_m_addr, fp_m_din;
  logic [2:0]  fp_m_RW_type;

  logic [7:0]  mem [0:255];
  bit          mem_init = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] sb_rdata;
  rsp_t        sb_q [$];

  dmem_arbiter #(.PRIO_MODE(0), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p1_valid(p1_valid),
    .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_we(p0_we), .p1_we(p1_we),
    .p0_lock(p0_lock), .p1_lock(p1_lock),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_rwtype(p0_rwtype), .p1_rwtype(p1_rwtype),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p1_rsp_valid(p1_rsp_valid),
    .p0_rsp_err(p0_rsp_err), .p1_rsp_err(p1_rsp_err),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .m_W_en(m_W_en), .m_R_en(m_R_en), .m_addr(m_addr),
    .m_RW_type(m_RW_type), .m_din(m_din), .m_dout(m_dout)
  );

  dmem_arbiter #(.PRIO_MODE(1), .ADDR_W(32)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p1_valid(p1_valid),
    .p0_ready(fp_p0_ready), .p1_ready(fp_p1_ready),
    .p0_we(p0_we), .p1_we(p1_we),
    .p0_lock(p0_lock), .p1_lock(p1_lock),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_rwtype(p0_rwtype), .p1_rwtype(p1_rwtype),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_rsp_valid(fp_p0_rsp_valid), .p1_rsp_valid(fp_p1_rsp_valid),
    .p0_rsp_err(fp_p0_rsp_err), .p1_rsp_err(fp_p1_rsp_err),
    .p0_rdata(fp_p0_rdata), .p1_rdata(fp_p1_rdata),
    .m_W_en(fp_m_W_en), .m_R_en(fp_m_R_en), .m_addr(fp_m_addr),
    .m_RW_type(fp_m_RW_type), .m_din(fp_m_din), .m_dout(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: combinational, extending read
  always_comb begin
    logic [7:0] a;
    a = m_addr[7:0];
    case (m_RW_type[1:0])
      2'b00:   m_dout = m_RW_type[2] ? {24'h0, mem[a]} : {{24{mem[a][7]}}, mem[a]};
      2'b01:   m_dout = m_RW_type[2] ? {16'h0, mem[8'(a + 1)], mem[a]}
                                     : {{16{mem[8'(a + 1)][7]}}, mem[8'(a + 1)], mem[a]};
      default: m_dout = {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[a]};
    endcase
  end

  // dmem model: preload on the first edge, then commit stores
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h20] <= 8'h11;
      mem[8'h21] <= 8'h22;
      mem[8'h22] <= 8'h33;
      mem[8'h23] <= 8'h44;
      mem[8'h30] <= 8'h80;
      mem_init   <= 1'b1;
    end else if (m_W_en) begin
      case (m_RW_type[1:0])
        2'b00: mem[m_addr[7:0]] <= m_din[7:0];
        2'b01: begin
          mem[m_addr[7:0]]          <= m_din[7:0];
          mem[8'(m_addr[7:0] + 1)]  <= m_din[15:8];
        end
        default: begin
          mem[m_addr[7:0]]          <= m_din[7:0];
          mem[8'(m_addr[7:0] + 1)]  <= m_din[15:8];
          mem[8'(m_addr[7:0] + 2)]  <= m_din[23:16];
          mem[8'(m_addr[7:0] + 3)]  <= m_din[31:24];
        end
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_p0(input logic v, input logic we, input logic lk,
                        input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    p0_valid = v; p0_we = we; p0_lock = lk; p0_addr = a; p0_rwtype = t; p0_wdata = d;
  endtask

  task automatic set_p1(input logic v, input logic we, input logic lk,
                        input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    p1_valid = v; p1_we = we; p1_lock = lk; p1_addr = a; p1_rwtype = t; p1_wdata = d;
  endtask

  // One clock: check grant and dmem drive, queue expected response, then check it.
  task automatic cyc(input logic [1:0] eg, input logic ee, input logic [31:0] eld, input int efp);
    rsp_t        e;
    logic        wwe;
    logic [31:0] waddr, wdin;
    logic [2:0]  wt;
    @(negedge clk);
    chk("grant", 32'({p1_ready, p0_ready}), 32'(eg));
    if (efp >= 0) chk("grant_fixed", 32'({fp_p1_ready, fp_p0_ready}), 32'(efp));
    wwe   = eg[1] ? p1_we     : p0_we;
    waddr = eg[1] ? p1_addr   : p0_addr;
    wt    = eg[1] ? p1_rwtype : p0_rwtype;
    wdin  = eg[1] ? p1_wdata  : p0_wdata;
    if (eg != 2'b00) begin
      chk("m_W_en", 32'(m_W_en), 32'(!ee && wwe));
      chk("m_R_en", 32'(m_R_en), 32'(!ee && !wwe));
      if (!ee) begin
        chk("m_addr", m_addr, waddr);
        chk("m_RW_type", 32'(m_RW_type), 32'(wt));
        if (wwe) chk("m_din", m_din, wdin);
      end
    end else begin
      chk("idle_en", 32'({m_W_en, m_R_en}), 32'h0);
    end
    if (eg != 2'b00 && !ee && !wwe) sb_rdata = eld;
    e.vld   = eg;
    e.err   = ee;
    e.rdata = sb_rdata;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("rsp_valid", 32'({p1_rsp_valid, p0_rsp_valid}), 32'(e.vld));
    chk("rsp_err", 32'({p1_rsp_err, p0_rsp_err}), 32'(e.err ? e.vld : 2'b00));
    chk("p0_rdata", p0_rdata, e.rdata);
    chk("p1_rdata", p1_rdata, e.rdata);
  endtask

  initial begin
    rst_n    = 1'b0;
    sb_rdata = 32'h0;
    set_p0(0, 0, 0, 32'h0, 3'b010, 32'h0);
    set_p1(0, 0, 0, 32'h0, 3'b010, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    // reset state, with a request offered while reset is held
    set_p0(1, 1, 0, 32'h10, 3'b010, 32'h55555555);
    #1;
    chk("reset_ready", 32'({p1_ready, p0_ready}), 32'h0);
    chk("reset_m_en", 32'({m_W_en, m_R_en}), 32'h0);
    chk("reset_rsp_valid", 32'({p1_rsp_valid, p0_rsp_valid}), 32'h0);
    chk("reset_rdata", p0_rdata, 32'h0);
    set_p0(0, 0, 0, 32'h0, 3'b010, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // store then load a word on port 0
    set_p0(1, 1, 0, 32'h10, 3'b010, 32'h12345678);
    cyc(2'b01, 0, 32'h0, -1);
    set_p0(1, 0, 0, 32'h10, 3'b010, 32'h0);
    cyc(2'b01, 0, 32'h12345678, -1);
    set_p0(0, 0, 0, 32'h0, 3'b010, 32'h0);
    set_p1(1, 0, 0, 32'h10, 3'b010, 32'h0);
    cyc(2'b10, 0, 32'h12345678, -1);

    // contention: round-robin alternates, fixed priority keeps port 0
    set_p0(1, 0, 0, 32'h10, 3'b010, 32'h0);
    set_p1(1, 0, 0, 32'h10, 3'b010, 32'h0);
    cyc(2'b01, 0, 32'h12345678, 1);
    cyc(2'b10, 0, 32'h12345678, 1);
    cyc(2'b01, 0, 32'h12345678, 1);
    cyc(2'b10, 0, 32'h12345678, 1);

    // locked read-modify-write on port 1 while port 0 keeps requesting
    set_p1(1, 0, 1, 32'h20, 3'b010, 32'h0);
    cyc(2'b01, 0, 32'h12345678, 1);
    cyc(2'b10, 0, 32'h44332211, -1);
    set_p1(1, 1, 0, 32'h21, 3'b000, 32'h000000AA);
    cyc(2'b10, 0, 32'h0, -1);
    set_p1(0, 0, 0, 32'h0, 3'b010, 32'h0);
    cyc(2'b01, 0, 32'h12345678, -1);
    set_p0(1, 0, 0, 32'h20, 3'b010, 32'h0);
    cyc(2'b01, 0, 32'h4433AA11, -1);

    // misaligned and reserved-size requests are acknowledged with an error
    set_p0(1, 0, 0, 32'h13, 3'b001, 32'h0);
    cyc(2'b01, 1, 32'h0, -1);
    set_p0(1, 0, 0, 32'h22, 3'b010, 32'h0);
    cyc(2'b01, 1, 32'h0, -1);
    set_p0(0, 0, 0, 32'h0, 3'b010, 32'h0);
    set_p1(1, 0, 0, 32'h0, 3'b011, 32'h0);
    cyc(2'b10, 1, 32'h0, -1);
    set_p1(1, 1, 0, 32'h31, 3'b001, 32'h0000BEEF);
    cyc(2'b10, 1, 32'h0, -1);
    set_p1(0, 0, 0, 32'h0, 3'b010, 32'h0);

    // signed and unsigned byte loads of 0x80
    set_p0(1, 0, 0, 32'h30, 3'b000, 32'h0);
    cyc(2'b01, 0, 32'hFFFFFF80, -1);
    set_p0(1, 0, 0, 32'h30, 3'b100, 32'h0);
    cyc(2'b01, 0, 32'h00000080, -1);

    // lock drops when the locked port goes idle
    set_p0(1, 0, 1, 32'h30, 3'b100, 32'h0);
    cyc(2'b01, 0, 32'h00000080, -1);
    set_p0(0, 0, 0, 32'h0, 3'b010, 32'h0);
    set_p1(1, 0, 0, 32'h20, 3'b010, 32'h0);
    cyc(2'b10, 0, 32'h4433AA11, -1);
    set_p1(0, 0, 0, 32'h0, 3'b010, 32'h0);
    cyc(2'b00, 0, 32'h0, -1);

    // reset during an accepted store with a load response outstanding
    set_p0(1, 0, 0, 32'h10, 3'b010, 32'h0);
    cyc(2'b01, 0, 32'h12345678, -1);
    set_p0(1, 1, 0, 32'h40, 3'b010, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'({p1_ready, p0_ready}), 32'h0);
    chk("rst_m_W_en", 32'(m_W_en), 32'h0);
    chk("rst_rsp_dropped", 32'({p1_rsp_valid, p0_rsp_valid}), 32'h0);
    chk("rst_rdata", p0_rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_m_W_en", 32'(m_W_en), 32'h0);
    @(negedge clk);
    set_p0(0, 0, 0, 32'h0, 3'b010, 32'h0);
    rst_n = 1'b1;
    sb_q.delete();
    sb_rdata = 32'h0;
    @(posedge clk);
    #1;
    set_p0(1, 0, 0, 32'h40, 3'b010, 32'h0);
    set_p1(1, 0, 0, 32'h40, 3'b010, 32'h0);
    cyc(2'b01, 0, 32'h00000000, 1);
    cyc(2'b10, 0, 32'h00000000, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
